// File: rtl/rs_syndrome_calc.sv
// RS(255,223) syndrome calculator: Horner evaluation of the received polynomial at
// alpha^FCR..alpha^(FCR+NSYM-1), with a double-buffered output bank drained serially.
module rs_syndrome_calc #(
   parameter int         N         = 255,
   parameter int         NSYM      = 32,
   parameter int         FCR       = 1,
   parameter logic [8:0] PRIM_POLY = 9'h11d
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   input  logic       in_sop,
   output logic       syn_valid,
   input  logic       syn_ready,
   output logic [7:0] syn_data,
   output logic [4:0] syn_idx,
   output logic       syn_last,
   output logic       cw_err
);

   localparam int             CW       = $clog2(N);
   localparam int             IW       = $clog2(NSYM);
   localparam logic [CW-1:0]  LAST_SYM = CW'(N - 1);
   localparam logic [IW-1:0]  LAST_IDX = IW'(NSYM - 1);

   // Shift-and-add GF(2^8) product; with a constant operand it reduces to an XOR network.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = '0;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = aa[7] ? ((aa << 1) ^ PRIM_POLY[7:0]) : (aa << 1);
      end
      return p;
   endfunction

   function automatic logic [7:0] alpha_pow(input int e);
      logic [7:0] r;
      r = 8'h01;
      for (int i = 0; i < e; i++) r = gf_mul(r, 8'h02);
      return r;
   endfunction

   logic [7:0]    acc    [NSYM];
   logic [7:0]    bank   [NSYM];
   logic [7:0]    horner [NSYM];
   logic [CW-1:0] sym_cnt;
   logic [IW-1:0] idx_q;
   logic          bank_full;
   logic          cw_err_q;
   logic          cw_err_next;
   logic          sym_xfer;
   logic          syn_xfer;
   logic          sym_first;
   logic          sym_final;

   for (genvar j = 0; j < NSYM; j++) begin : g_root
      localparam logic [7:0] ROOT = alpha_pow(FCR + j);
      assign horner[j] = gf_mul(acc[j], ROOT) ^ in_data;
   end

   // NOTE: every always_comb output gets a default before any conditional update,
   // so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      cw_err_next = 1'b0;
      for (int j = 0; j < NSYM; j++) cw_err_next = cw_err_next | (|horner[j]);
   end

   // Registered state only: the final drain transfer does not bypass into in_ready.
   assign in_ready  = !((sym_cnt == LAST_SYM) && bank_full);
   assign sym_xfer  = in_valid && in_ready;
   assign syn_xfer  = syn_valid && syn_ready;
   assign sym_first = (sym_cnt == '0) || in_sop;
   assign sym_final = !sym_first && (sym_cnt == LAST_SYM);

   // NOTE: all state here uses non-blocking assignments so every register samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: accumulator and bank arrays are reset too, so syn_data reads 0x00
         // straight out of reset and a mid-drain reset leaves no stale syndromes.
         for (int j = 0; j < NSYM; j++) begin
            acc[j]  <= '0;
            bank[j] <= '0;
         end
         sym_cnt   <= '0;
         idx_q     <= '0;
         bank_full <= 1'b0;
         cw_err_q  <= 1'b0;
      end else begin
         if (sym_xfer) begin
            if (sym_first) begin
               // First symbol, or in_sop aborting a partial codeword.
               for (int j = 0; j < NSYM; j++) acc[j] <= in_data;
               sym_cnt <= CW'(1);
            end else if (sym_final) begin
               for (int j = 0; j < NSYM; j++) bank[j] <= horner[j];
               cw_err_q <= cw_err_next;
               sym_cnt  <= '0;
            end else begin
               for (int j = 0; j < NSYM; j++) acc[j] <= horner[j];
               sym_cnt <= sym_cnt + 1'b1;
            end
         end

         if (syn_xfer) idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;

         // A snapshot needs in_ready, which excludes a full bank at the last symbol,
         // so it never coincides with the final drain transfer.
         if (sym_xfer && sym_final)                 bank_full <= 1'b1;
         else if (syn_xfer && (idx_q == LAST_IDX)) bank_full <= 1'b0;
      end
   end

   assign syn_valid = bank_full;
   assign syn_data  = bank[idx_q];
   assign syn_idx   = idx_q;
   assign syn_last  = bank_full && (idx_q == LAST_IDX);
   assign cw_err    = cw_err_q;

endmodule

// File: tb/tb_rs_syndrome_calc.sv
// Directed bench for rs_syndrome_calc: table of single-error / encoded codewords plus
// hand-written back-pressure, abort and mid-drain reset sequences.
module tb_rs_syndrome_calc;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_sop = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       syn_ready = 1'b0;
   logic       in_ready;
   logic       syn_valid;
   logic [7:0] syn_data;
   logic [4:0] syn_idx;
   logic       syn_last;
   logic       cw_err;

   rs_syndrome_calc dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_sop    (in_sop),
      .syn_valid (syn_valid),
      .syn_ready (syn_ready),
      .syn_data  (syn_data),
      .syn_idx   (syn_idx),
      .syn_last  (syn_last),
      .cw_err    (cw_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] idx;
      logic [7:0] data;
      logic       last;
      logic       err;
   } xfer_t;

   typedef struct {
      int         kind;     // 0: encoder codeword, 1: all-zero plus one error
      int         pos;
      logic [7:0] val;
      logic [7:0] exp_s0;
      logic       exp_err;
   } vec_t;

   int         n_vec = 0;
   int         n_err = 0;
   int         stalls;
   logic [7:0] exp_t [256];
   int         log_t [256];
   logic [7:0] gen   [33];
   logic [7:0] cw    [255];
   logic [7:0] exp_syn [32];
   logic [7:0] exp_a   [32];
   logic [7:0] exp_b   [32];
   xfer_t      q [$];
   vec_t       vt [6];

   // Transfers are recorded at the falling edge, ahead of the rising edge that performs them.
   always @(negedge clk) begin
      xfer_t t;
      if (rst_n && syn_valid && syn_ready) begin
         t.idx  = syn_idx;
         t.data = syn_data;
         t.last = syn_last;
         t.err  = cw_err;
         q.push_back(t);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s: wait bound expired", name);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
      if (a == 8'h00 || b == 8'h00) return 8'h00;
      return exp_t[(log_t[a] + log_t[b]) % 255];
   endfunction

   task automatic build_tables();
      logic [8:0] t;
      t = 9'h001;
      for (int i = 0; i < 255; i++) begin
         exp_t[i] = t[7:0];
         log_t[t[7:0]] = i;
         t = t << 1;
         if (t[8]) t = t ^ 9'h11d;
      end
      exp_t[255] = 8'h01;
      // g(x) = prod_{i=1..32} (x + alpha^i), gen[k] is the coefficient of x^k.
      for (int k = 0; k < 33; k++) gen[k] = 8'h00;
      gen[0] = 8'h01;
      for (int i = 1; i <= 32; i++) begin
         for (int k = 32; k > 0; k--) gen[k] = gen[k-1] ^ mul(gen[k], exp_t[i]);
         gen[0] = mul(gen[0], exp_t[i]);
      end
   endtask

   // Systematic encoder: 223 data symbols then 32 parity symbols, highest degree first.
   task automatic make_enc(input int mode);
      logic [7:0] par [32];
      logic [7:0] fb;
      for (int k = 0; k < 32; k++) par[k] = 8'h00;
      for (int i = 0; i < 223; i++) begin
         cw[i] = (mode == 0) ? 8'(i + 1) : 8'((i * 37 + mode * 11) & 255);
         fb = cw[i] ^ par[31];
         for (int k = 31; k > 0; k--) par[k] = par[k-1] ^ mul(fb, gen[k]);
         par[0] = mul(fb, gen[0]);
      end
      for (int k = 0; k < 32; k++) cw[223 + k] = par[31 - k];
   endtask

   task automatic make_zero();
      for (int i = 0; i < 255; i++) cw[i] = 8'h00;
   endtask

   task automatic model_syn();
      logic [7:0] s;
      for (int j = 0; j < 32; j++) begin
         s = 8'h00;
         for (int i = 0; i < 255; i++) s = mul(s, exp_t[j + 1]) ^ cw[i];
         exp_syn[j] = s;
      end
   endtask

   // Drives cw[from..to]; in_valid is left high after the last accepted symbol.
   task automatic send_range(input int from, input int to, input bit sop_first);
      int w;
      for (int i = from; i <= to; i++) begin
         in_valid = 1'b1;
         in_data  = cw[i];
         in_sop   = sop_first && (i == from);
         w = 0;
         while (!in_ready) begin
            tick();
            w++;
            stalls++;
            if (w > 2000) begin
               timeout_fail("in_ready wait");
               in_sop = 1'b0;
               return;
            end
         end
         tick();
      end
      in_sop = 1'b0;
   endtask

   task automatic expect_set(input string name, input logic [7:0] e [32],
                             output logic [7:0] s0_got, output logic err_got);
      int    w;
      logic  err_exp;
      xfer_t t;
      s0_got  = 8'hxx;
      err_got = 1'bx;
      w = 0;
      while (q.size() < 32) begin
         tick();
         w++;
         if (w > 600) begin
            timeout_fail({name, " drain"});
            return;
         end
      end
      err_exp = 1'b0;
      for (int k = 0; k < 32; k++) err_exp = err_exp | (|e[k]);
      for (int k = 0; k < 32; k++) begin
         t = q.pop_front();
         if (k == 0) begin
            s0_got  = t.data;
            err_got = t.err;
         end
         check($sformatf("%s S[%0d] {idx,data,last,err}", name, k),
               32'({t.idx, t.data, t.last, t.err}),
               32'({5'(k), e[k], (k == 31), err_exp}));
      end
   endtask

   initial begin
      logic [7:0] s0;
      logic       e0;
      int         c;

      vt[0] = '{kind: 0, pos: 0,   val: 8'h00, exp_s0: 8'h00, exp_err: 1'b0};
      vt[1] = '{kind: 1, pos: 254, val: 8'h01, exp_s0: 8'h01, exp_err: 1'b1};
      vt[2] = '{kind: 1, pos: 0,   val: 8'h01, exp_s0: 8'h8e, exp_err: 1'b1};
      vt[3] = '{kind: 1, pos: 253, val: 8'h01, exp_s0: 8'h02, exp_err: 1'b1};
      vt[4] = '{kind: 1, pos: 254, val: 8'h05, exp_s0: 8'h05, exp_err: 1'b1};
      vt[5] = '{kind: 1, pos: 252, val: 8'h01, exp_s0: 8'h04, exp_err: 1'b1};

      build_tables();
      repeat (3) tick();
      check("reset in_ready",  32'(in_ready),  32'd1);
      check("reset syn_valid", 32'(syn_valid), 32'd0);
      check("reset syn_data",  32'(syn_data),  32'h00);
      check("reset syn_idx",   32'(syn_idx),   32'd0);
      check("reset syn_last",  32'(syn_last),  32'd0);
      check("reset cw_err",    32'(cw_err),    32'd0);
      rst_n = 1'b1;
      syn_ready = 1'b1;
      tick();

      // All-zero codeword with first-output latency check.
      make_zero();
      model_syn();
      send_range(0, 254, 1'b1);
      in_valid = 1'b0;
      check("zero latency syn_valid", 32'(syn_valid), 32'd1);
      check("zero latency syn_idx",   32'(syn_idx),   32'd0);
      expect_set("zero", exp_syn, s0, e0);

      for (int v = 0; v < 6; v++) begin
         if (vt[v].kind == 0) make_enc(0);
         else begin
            make_zero();
            cw[vt[v].pos] = vt[v].val;
         end
         model_syn();
         send_range(0, 254, 1'b1);
         in_valid = 1'b0;
         check($sformatf("vec%0d latency syn_valid", v), 32'(syn_valid), 32'd1);
         expect_set($sformatf("vec%0d", v), exp_syn, s0, e0);
         check($sformatf("vec%0d S0 hand value", v), 32'(s0), 32'(vt[v].exp_s0));
         check($sformatf("vec%0d cw_err hand value", v), 32'(e0), 32'(vt[v].exp_err));
      end

      // Four encoded codewords back-to-back with in_valid held high.
      make_enc(0);
      model_syn();
      stalls = 0;
      for (int r = 0; r < 4; r++) send_range(0, 254, 1'b1);
      in_valid = 1'b0;
      check("b2b in_ready low cycles", 32'(stalls), 32'd0);
      for (int r = 0; r < 4; r++) expect_set($sformatf("b2b%0d", r), exp_syn, s0, e0);

      // Back-pressure: A fills the bank, B stalls on its last symbol.
      syn_ready = 1'b0;
      make_zero();
      cw[254] = 8'h01;
      model_syn();
      exp_a = exp_syn;
      send_range(0, 254, 1'b1);
      in_valid = 1'b0;
      tick();
      make_enc(3);
      cw[10] = cw[10] ^ 8'h33;
      model_syn();
      exp_b = exp_syn;
      stalls = 0;
      send_range(0, 253, 1'b1);
      check("bp no early stall", 32'(stalls), 32'd0);
      in_data  = cw[254];
      in_valid = 1'b1;
      repeat (4) tick();
      check("bp stall in_ready", 32'(in_ready),  32'd0);
      check("bp stall syn_idx",  32'(syn_idx),   32'd0);
      check("bp no transfers",   32'(q.size()),  32'd0);
      syn_ready = 1'b1;
      c = 0;
      while (!in_ready && c < 100) begin
         tick();
         c++;
      end
      check("bp cycles to in_ready", 32'(c), 32'd32);
      tick();
      in_valid = 1'b0;
      check("bp B syn_valid", 32'(syn_valid), 32'd1);
      check("bp B syn_idx",   32'(syn_idx),   32'd0);
      expect_set("bpA", exp_a, s0, e0);
      expect_set("bpB", exp_b, s0, e0);

      // in_sop abort after 100 nonzero symbols, then a full zero codeword.
      for (int i = 0; i < 100; i++) cw[i] = 8'h5a;
      send_range(0, 99, 1'b1);
      make_zero();
      model_syn();
      send_range(0, 254, 1'b1);
      in_valid = 1'b0;
      repeat (40) tick();
      check("abort set count", 32'(q.size()), 32'd32);
      expect_set("abort", exp_syn, s0, e0);
      q.delete();

      // Reset in the middle of a drain.
      make_zero();
      cw[254] = 8'h01;
      send_range(0, 254, 1'b1);
      in_valid = 1'b0;
      c = 0;
      while (syn_idx != 5'd10 && c < 100) begin
         tick();
         c++;
      end
      if (c >= 100) timeout_fail("wait syn_idx 10");
      rst_n = 1'b0;
      #1;
      check("midreset syn_valid", 32'(syn_valid), 32'd0);
      check("midreset in_ready",  32'(in_ready),  32'd1);
      check("midreset syn_idx",   32'(syn_idx),   32'd0);
      check("midreset syn_data",  32'(syn_data),  32'h00);
      check("midreset cw_err",    32'(cw_err),    32'd0);
      tick();
      rst_n = 1'b1;
      q.delete();
      tick();
      make_zero();
      model_syn();
      send_range(0, 254, 1'b1);
      in_valid = 1'b0;
      expect_set("post-reset", exp_syn, s0, e0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/rs_syndrome_calc.md
# rs_syndrome_calc

RS(255,223) syndrome calculator, the first stage of the receive-side decoder, directly downstream of the RS encoder and channel. It accepts a stream of 255-symbol codewords, highest-degree coefficient first, and evaluates the received polynomial r(x) at the 32 generator roots α^1..α^32 over GF(2^8), primitive polynomial 0x11d. Each finished syndrome set is snapshotted into an output bank and drained serially to the key-equation solver while the next codeword accumulates.

## Interface
- N, 255: symbols per codeword.
- NSYM, 32: syndromes per codeword (N−K).
- FCR, 1: first consecutive root exponent. Syndrome j uses α^(FCR+j).
- PRIM_POLY, 9'h11d: field generator polynomial.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block can accept a symbol.
- in_data  in  8  received symbol.
- in_sop  in  1  marks the first symbol of a codeword; qualified by in_valid.
- syn_valid  out  1  syn_data valid.
- syn_ready  in  1  consumer accepts the syndrome.
- syn_data  out  8  syndrome S_(FCR+syn_idx).
- syn_idx  out  5  index 0..NSYM−1 of the presented syndrome.
- syn_last  out  1  high when syn_idx == NSYM−1 and syn_valid is high.
- cw_err  out  1  OR of all syndromes in the bank. Stable for the whole drain.

## Operation
- Handshakes: a symbol transfers when in_valid && in_ready. A syndrome transfers when syn_valid && syn_ready. State changes only on transfers; gaps in in_valid are allowed anywhere.
- Constants α^(FCR+j), j=0..31, are computed at elaboration by a function from PRIM_POLY. They feed 32 instances of the team's constant GF(2^8) multiplier and adder.
- Accumulator bank acc[0..31] and symbol counter sym_cnt (0..N−1) drive a Horner update on each accepted symbol d:
  - sym_cnt==0: acc[j] <= d.
  - otherwise: acc[j] <= acc[j]·α^(FCR+j) ⊕ d.
- An accepted symbol counts as first when sym_cnt==0 or in_sop==1.
  - in_sop with sym_cnt≠0 aborts the partial codeword: acc restarts from d and sym_cnt <= 1.
  - No output is produced for the aborted codeword.
- Accepting the symbol at sym_cnt==N−1:
  - The final values acc[j]·α^(FCR+j) ⊕ d are written directly into out bank[0..31].
  - cw_err <= OR-reduce of those values.
  - bank_full <= 1, sym_cnt <= 0.
  - The final values are not stored in acc.
- Drain:
  - syn_valid = bank_full, syn_data = bank[syn_idx].
  - Each transfer increments syn_idx.
  - The transfer with syn_idx==NSYM−1 sets bank_full <= 0 and syn_idx <= 0.
- Back-pressure: in_ready = !(sym_cnt==N−1 && bank_full). This uses registered state only, with no same-cycle bypass from the final drain transfer.
- States, implicit in (sym_cnt, bank_full):
  - ACCUM: bank empty.
  - ACCUM+DRAIN: bank full, sym_cnt < N−1.
  - STALL: bank full, sym_cnt == N−1.
  - STALL → ACCUM+DRAIN one cycle after the last syndrome transfer.

## Timing
- Reset values:
  - in_ready 1, syn_valid 0, syn_data 0x00, syn_idx 0, syn_last 0, cw_err 0.
  - sym_cnt 0, all acc and bank entries 0x00.
- Throughput: one symbol per cycle sustained while the consumer drains 32 syndromes within 255 cycles.
- Latency: last symbol accepted at edge t → syn_valid high, syn_idx 0 and cw_err valid in the cycle after edge t.
- Minimum drain is 32 cycles with syn_ready held high.
- The next codeword's first symbol may be accepted in the same cycle as the last symbol's snapshot edge + 1. There are no bubbles.
- Simultaneous final symbol and final drain transfer cannot occur: STALL holds in_ready low.
- Asynchronous reset mid-operation discards the accumulation and the bank. All outputs return to reset values immediately.

## Test plan
- Reset, then 255 symbols of 0x00 → syn_valid rises one cycle after the last symbol; 32 syndromes all 0x00, syn_idx 0..31, syn_last on idx 31, cw_err=0.
- Valid codeword from the team's RS(255,223) encoder model, data 0x01..0xDF with 32 parity symbols → all 32 syndromes 0x00, cw_err=0. Repeat back-to-back ×4 with continuous in_valid → in_ready never drops.
- Single-error codewords, built from an all-zero codeword:
  - Only the last symbol = 0x01 → every syndrome 0x01, cw_err=1.
  - Only the first symbol = 0x01 → S_1 (idx 0) = 0x8e (α^254), cw_err=1.
- Back-pressure: syn_ready=0 through codeword A and into codeword B → in_ready falls when B reaches sym_cnt 254; B's last symbol is held. Then syn_ready=1 → A's 32 syndromes drain, in_ready returns the cycle after A's idx-31 transfer, then B's syndromes appear with correct values.
- in_sop asserted at symbol 100 of a codeword, then 254 further zeros → no syndromes for the aborted codeword; one zero-syndrome set after 255 symbols counted from the restart.
- Reset asserted mid-drain at syn_idx 10 → syn_valid 0 and in_ready 1 immediately; the next all-zero codeword yields 32 zeros starting at idx 0.
